// File: rtl/mpi_bridge_mc.sv
// MPI bus slave: synchronises the async CPU bus into clk100m and decodes it to NCH register
// channels, with read-valid handshake/timeout, W1C interrupt aggregation and an error counter.
module mpi_bridge_mc #(
    parameter int unsigned   AW      = 25,
    parameter int unsigned   DW      = 16,
    parameter int unsigned   NCH     = 8,
    parameter int unsigned   LAW     = 12,
    parameter int unsigned   TMO     = 255,
    parameter logic [DW-1:0] VERSION = 16'h0200
) (
    input  logic              clk100m,
    input  logic              rst,
    input  logic [AW-1:0]     mpi_a,
    input  logic [DW-1:0]     mpi_din,
    output logic [DW-1:0]     mpi_dout,
    input  logic              mpi_cs,
    input  logic              mpi_wr,
    output logic              mpi_en,
    output logic              mpi_int,
    output logic [NCH-1:0]    cpu_cs,
    output logic [LAW-1:0]    cpu_addr,
    output logic [DW-1:0]     cpu_wdata,
    output logic              cpu_wen,
    output logic              cpu_ren,
    input  logic [NCH*DW-1:0] cpu_rdata,
    input  logic [NCH-1:0]    cpu_rvld,
    input  logic [NCH-1:0]    int_src
);

    localparam logic [DW-1:0] DeadVal = DW'(16'hDEAD);

    typedef enum logic [1:0] {StIdle, StStrb, StRwait, StDone} state_e;

    function automatic logic is_unmapped(input logic [AW-1:0] a);
        logic [3:0] ch;
        logic       hi;
        ch = a[LAW+3:LAW];
        hi = 1'b0;
        for (int unsigned i = LAW + 4; i <= AW - 2; i++) begin
            hi = hi | a[i];
        end
        return hi || (32'(ch) >= NCH);
    endfunction

    state_e         state_q, state_d;
    logic           cs_s1_q, cs_s2_q, cs_prev_q;
    logic           wr_s1_q, wr_s2_q;
    logic [1:0]     fill_q;
    logic           armed_q, armed_d;
    logic [AW-1:0]  a_q, a_d;
    logic [DW-1:0]  din_q, din_d;
    logic           wr_q, wr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    err_q, err_d;
    logic [NCH-1:0] stat_q, stat_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [NCH-1:0] int_src_q;
    logic [DW-1:0]  dout_q, dout_d;
    logic           int_q, int_d;
    logic [NCH-1:0] cpu_cs_q, cpu_cs_d;
    logic [LAW-1:0] cpu_addr_q, cpu_addr_d;
    logic [DW-1:0]  cpu_wdata_q, cpu_wdata_d;
    logic           cpu_wen_q, cpu_wen_d;
    logic           cpu_ren_q, cpu_ren_d;

    logic [3:0]     ch_q;
    logic [DW-1:0]  rd_sel;
    logic           rvld_sel;
    logic [DW-1:0]  reg_rd;
    logic [NCH-1:0] clr;
    logic           start;
    logic           err_inc;

    assign ch_q = a_q[LAW+3:LAW];

    // Only a falling edge seen after cs was observed high post-reset starts an access.
    assign start = armed_q & cs_prev_q & ~cs_s2_q;

    always_comb begin
        rd_sel   = '0;
        rvld_sel = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_q == 4'(k)) begin
                rd_sel   = cpu_rdata[k*DW +: DW];
                rvld_sel = cpu_rvld[k];
            end
        end
    end

    always_comb begin
        reg_rd = '0;
        case (a_q[LAW-1:0])
            LAW'(0): reg_rd = DW'(stat_q);
            LAW'(1): reg_rd = DW'(mask_q);
            LAW'(2): reg_rd = VERSION;
            LAW'(3): reg_rd = DW'(err_q);
            default: reg_rd = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | (fill_q[1] & cs_s2_q);
        a_d         = a_q;
        din_d       = din_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        mask_d      = mask_q;
        dout_d      = dout_q;
        cpu_cs_d    = '0;
        cpu_addr_d  = '0;
        cpu_wdata_d = '0;
        cpu_wen_d   = 1'b0;
        cpu_ren_d   = 1'b0;
        clr         = '0;
        err_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d   = mpi_a;
                    din_d = mpi_din;
                    wr_d  = wr_s2_q;
                    if (mpi_a[AW-1]) begin
                        state_d = StStrb;
                    end else if (is_unmapped(mpi_a)) begin
                        err_inc = 1'b1;
                        if (!wr_s2_q) dout_d = DeadVal;
                        state_d = StDone;
                    end else begin
                        cpu_cs_d    = NCH'(1) << mpi_a[LAW+3:LAW];
                        cpu_addr_d  = mpi_a[LAW-1:0];
                        cpu_wdata_d = mpi_din;
                        cpu_wen_d   = wr_s2_q;
                        cpu_ren_d   = ~wr_s2_q;
                        state_d     = StStrb;
                    end
                end
            end
            StStrb: begin
                state_d = StDone;
                if (a_q[AW-1]) begin
                    if (wr_q) begin
                        case (a_q[LAW-1:0])
                            LAW'(0): clr    = din_q[NCH-1:0];
                            LAW'(1): mask_d = din_q[NCH-1:0];
                            LAW'(3): err_d  = '0;
                            default: ;
                        endcase
                    end else begin
                        dout_d = reg_rd;
                    end
                end else if (!wr_q) begin
                    if (rvld_sel) begin
                        dout_d = rd_sel;
                    end else begin
                        cnt_d   = '0;
                        state_d = StRwait;
                    end
                end
            end
            StRwait: begin
                if (rvld_sel) begin
                    dout_d  = rd_sel;
                    state_d = StDone;
                end else if (cnt_q == 16'(TMO - 1)) begin
                    dout_d  = DeadVal;
                    err_inc = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                if (cs_s2_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;

        // A new rising edge in the same cycle as a W1C clear keeps the bit set.
        stat_d = (stat_q & ~clr) | (int_src & ~int_src_q);
        int_d  = |(stat_q & mask_q);
    end

    always_ff @(posedge clk100m or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_prev_q   <= 1'b1;
            wr_s1_q     <= 1'b0;
            wr_s2_q     <= 1'b0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            a_q         <= '0;
            din_q       <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            err_q       <= '0;
            stat_q      <= '0;
            mask_q      <= '0;
            int_src_q   <= '0;
            dout_q      <= '0;
            int_q       <= 1'b0;
            cpu_cs_q    <= '0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
            cpu_wen_q   <= 1'b0;
            cpu_ren_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_s1_q     <= mpi_cs;
            cs_s2_q     <= cs_s1_q;
            cs_prev_q   <= cs_s2_q;
            wr_s1_q     <= mpi_wr;
            wr_s2_q     <= wr_s1_q;
            fill_q      <= {fill_q[0], 1'b1};
            armed_q     <= armed_d;
            a_q         <= a_d;
            din_q       <= din_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            stat_q      <= stat_d;
            mask_q      <= mask_d;
            int_src_q   <= int_src;
            dout_q      <= dout_d;
            int_q       <= int_d;
            cpu_cs_q    <= cpu_cs_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_wdata_q <= cpu_wdata_d;
            cpu_wen_q   <= cpu_wen_d;
            cpu_ren_q   <= cpu_ren_d;
        end
    end

    assign mpi_dout  = dout_q;
    assign mpi_en    = (state_q == StDone);
    assign mpi_int   = int_q;
    assign cpu_cs    = cpu_cs_q;
    assign cpu_addr  = cpu_addr_q;
    assign cpu_wdata = cpu_wdata_q;
    assign cpu_wen   = cpu_wen_q;
    assign cpu_ren   = cpu_ren_q;

endmodule

// File: tb/tb_mpi_bridge_mc.sv
// Directed self-checking bench for mpi_bridge_mc (default parameters: NCH=8, TMO=255).
module tb_mpi_bridge_mc;

    logic         clk = 1'b0;
    logic         rst;
    logic [24:0]  mpi_a;
    logic [15:0]  mpi_din;
    logic [15:0]  mpi_dout;
    logic         mpi_cs;
    logic         mpi_wr;
    logic         mpi_en;
    logic         mpi_int;
    logic [7:0]   cpu_cs;
    logic [11:0]  cpu_addr;
    logic [15:0]  cpu_wdata;
    logic         cpu_wen;
    logic         cpu_ren;
    logic [127:0] cpu_rdata;
    logic [7:0]   cpu_rvld;
    logic [7:0]   int_src;

    int checks   = 0;
    int failures = 0;
    int wen_cnt  = 0;
    int ren_cnt  = 0;

    mpi_bridge_mc dut (
        .clk100m   (clk),
        .rst       (rst),
        .mpi_a     (mpi_a),
        .mpi_din   (mpi_din),
        .mpi_dout  (mpi_dout),
        .mpi_cs    (mpi_cs),
        .mpi_wr    (mpi_wr),
        .mpi_en    (mpi_en),
        .mpi_int   (mpi_int),
        .cpu_cs    (cpu_cs),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wen   (cpu_wen),
        .cpu_ren   (cpu_ren),
        .cpu_rdata (cpu_rdata),
        .cpu_rvld  (cpu_rvld),
        .int_src   (int_src)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_wen === 1'b1) wen_cnt++;
        if (cpu_ren === 1'b1) ren_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_acc(input logic [24:0] a, input logic [15:0] d, input logic wr);
        mpi_a   = a;
        mpi_din = d;
        mpi_wr  = wr;
        mpi_cs  = 1'b0;
    endtask

    task automatic wait_en(input int max, output int n);
        n = 0;
        while (mpi_en !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_acc();
        int n;
        mpi_cs = 1'b1;
        n = 0;
        while (mpi_en !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (mpi_en !== 1'b0) begin
            failures++;
            $display("FAIL en_release: mpi_en=%b after cs release, required 0", mpi_en);
        end
        tick();
        tick();
    endtask

    task automatic rd_int(input logic [11:0] la, output logic [15:0] d);
        int n;
        begin_acc({1'b1, 12'h000, la}, 16'h0000, 1'b0);
        wait_en(20, n);
        d = (mpi_en === 1'b1) ? mpi_dout : 16'hxxxx;
        finish_acc();
    endtask

    task automatic wr_int(input logic [11:0] la, input logic [15:0] d);
        int n;
        begin_acc({1'b1, 12'h000, la}, d, 1'b1);
        wait_en(20, n);
        finish_acc();
    endtask

    task automatic test_reset();
        checks++;
        if ({mpi_en, mpi_int, cpu_wen, cpu_ren} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_ctrl: en/int/wen/ren=%b required 0000",
                     {mpi_en, mpi_int, cpu_wen, cpu_ren});
        end
        checks++;
        if (mpi_dout !== 16'h0000) begin
            failures++;
            $display("FAIL rst_dout: got %h required 0000", mpi_dout);
        end
        checks++;
        if ({cpu_cs, cpu_addr, cpu_wdata} !== 36'h0) begin
            failures++;
            $display("FAIL rst_cpu: cs/addr/wdata=%h required 0", {cpu_cs, cpu_addr, cpu_wdata});
        end
    endtask

    task automatic test_write();
        wen_cnt = 0;
        begin_acc(25'h0002005, 16'h1234, 1'b1);
        tick();
        tick();
        checks++;
        if (cpu_wen !== 1'b0) begin
            failures++;
            $display("FAIL wr_early: cpu_wen=%b in cycle 2, required 0", cpu_wen);
        end
        tick();
        checks++;
        if ({cpu_wen, cpu_ren, cpu_cs} !== {1'b1, 1'b0, 8'h04}) begin
            failures++;
            $display("FAIL wr_strobe: wen/ren/cs=%b/%b/%h required 1/0/04",
                     cpu_wen, cpu_ren, cpu_cs);
        end
        checks++;
        if ({cpu_addr, cpu_wdata} !== {12'h005, 16'h1234}) begin
            failures++;
            $display("FAIL wr_data: addr/wdata=%h/%h required 005/1234", cpu_addr, cpu_wdata);
        end
        tick();
        checks++;
        if ({cpu_wen, mpi_en} !== 2'b01) begin
            failures++;
            $display("FAIL wr_done: wen/en=%b/%b required 0/1", cpu_wen, mpi_en);
        end
        repeat (5) tick();
        checks++;
        if (mpi_en !== 1'b1 || wen_cnt != 1) begin
            failures++;
            $display("FAIL wr_hold: en=%b wen_cycles=%0d required 1/1", mpi_en, wen_cnt);
        end
        finish_acc();
    endtask

    task automatic test_read_wait();
        ren_cnt = 0;
        cpu_rdata[5*16 +: 16] = 16'hBEEF;
        begin_acc(25'h0005010, 16'h0000, 1'b0);
        repeat (3) tick();
        checks++;
        if ({cpu_ren, cpu_cs, cpu_addr} !== {1'b1, 8'h20, 12'h010}) begin
            failures++;
            $display("FAIL rd_strobe: ren/cs/addr=%b/%h/%h required 1/20/010",
                     cpu_ren, cpu_cs, cpu_addr);
        end
        repeat (4) tick();
        cpu_rvld[5] = 1'b1;
        checks++;
        if (mpi_en !== 1'b0 || ren_cnt != 1) begin
            failures++;
            $display("FAIL rd_wait: en=%b ren_cycles=%0d required 0/1", mpi_en, ren_cnt);
        end
        tick();
        cpu_rvld[5] = 1'b0;
        checks++;
        if (mpi_en !== 1'b1 || mpi_dout !== 16'hBEEF) begin
            failures++;
            $display("FAIL rd_data: en=%b dout=%h required 1/BEEF", mpi_en, mpi_dout);
        end
        finish_acc();
    endtask

    task automatic test_read_strb_valid();
        cpu_rdata[3*16 +: 16] = 16'h3C3C;
        cpu_rvld[3] = 1'b1;
        begin_acc(25'h0003abc, 16'h0000, 1'b0);
        repeat (3) tick();
        checks++;
        if (cpu_ren !== 1'b1 || mpi_en !== 1'b0) begin
            failures++;
            $display("FAIL strbv_ren: ren/en=%b/%b required 1/0", cpu_ren, mpi_en);
        end
        tick();
        cpu_rvld[3] = 1'b0;
        checks++;
        if (mpi_en !== 1'b1 || mpi_dout !== 16'h3C3C) begin
            failures++;
            $display("FAIL strbv_data: en=%b dout=%h required 1/3C3C", mpi_en, mpi_dout);
        end
        finish_acc();
    endtask

    task automatic test_early_release();
        ren_cnt = 0;
        cpu_rdata[4*16 +: 16] = 16'h4444;
        begin_acc(25'h0004001, 16'h0000, 1'b0);
        repeat (3) tick();
        mpi_cs = 1'b1;
        repeat (6) tick();
        cpu_rvld[4] = 1'b1;
        tick();
        cpu_rvld[4] = 1'b0;
        checks++;
        if (mpi_en !== 1'b1 || mpi_dout !== 16'h4444) begin
            failures++;
            $display("FAIL early_data: en=%b dout=%h required 1/4444", mpi_en, mpi_dout);
        end
        tick();
        checks++;
        if (mpi_en !== 1'b0) begin
            failures++;
            $display("FAIL early_pulse: en=%b one cycle later, required 0", mpi_en);
        end
        repeat (4) tick();
        checks++;
        if (ren_cnt != 1) begin
            failures++;
            $display("FAIL early_restart: ren_cycles=%0d required 1", ren_cnt);
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [15:0] d;
        begin_acc(25'h0001002, 16'h0000, 1'b0);
        repeat (3) tick();
        wait_en(400, n);
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL tmo_latency: en after %0d cycles past ren, required 256", n);
        end
        checks++;
        if (mpi_dout !== 16'hDEAD) begin
            failures++;
            $display("FAIL tmo_dout: got %h required DEAD", mpi_dout);
        end
        finish_acc();
        rd_int(12'h003, d);
        checks++;
        if (d !== 16'h0001) begin
            failures++;
            $display("FAIL tmo_errcnt: got %h required 0001", d);
        end
    endtask

    task automatic test_unmapped();
        int n;
        logic [15:0] d;
        wen_cnt = 0;
        ren_cnt = 0;
        begin_acc(25'h0009000, 16'h0000, 1'b0);
        wait_en(20, n);
        checks++;
        if (n != 3 || mpi_dout !== 16'hDEAD) begin
            failures++;
            $display("FAIL unm_read: cycles=%0d dout=%h required 3/DEAD", n, mpi_dout);
        end
        finish_acc();
        begin_acc(25'h0010000, 16'h5555, 1'b1);
        wait_en(20, n);
        finish_acc();
        checks++;
        if (wen_cnt != 0 || ren_cnt != 0) begin
            failures++;
            $display("FAIL unm_strobe: wen=%0d ren=%0d cycles, required 0/0", wen_cnt, ren_cnt);
        end
        rd_int(12'h003, d);
        checks++;
        if (d !== 16'h0003) begin
            failures++;
            $display("FAIL unm_errcnt: got %h required 0003", d);
        end
        wr_int(12'h003, 16'h1111);
        rd_int(12'h003, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL err_clear: got %h required 0000", d);
        end
    endtask

    task automatic test_internal_regs();
        logic [15:0] d;
        wr_int(12'h002, 16'hFFFF);
        rd_int(12'h002, d);
        checks++;
        if (d !== 16'h0200) begin
            failures++;
            $display("FAIL version: got %h required 0200", d);
        end
        rd_int(12'h007, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL unused_reg: got %h required 0000", d);
        end
        wr_int(12'h001, 16'hFFFF);
        rd_int(12'h001, d);
        checks++;
        if (d !== 16'h00FF) begin
            failures++;
            $display("FAIL mask_width: got %h required 00FF", d);
        end
        wr_int(12'h001, 16'h0000);
    endtask

    task automatic test_interrupts();
        int n;
        logic [15:0] d;
        wr_int(12'h001, 16'h0001);
        int_src[0] = 1'b1;
        tick();
        checks++;
        if (mpi_int !== 1'b0) begin
            failures++;
            $display("FAIL int_lag: mpi_int=%b one cycle after edge, required 0", mpi_int);
        end
        tick();
        checks++;
        if (mpi_int !== 1'b1) begin
            failures++;
            $display("FAIL int_set: mpi_int=%b required 1", mpi_int);
        end
        int_src[0] = 1'b0;
        tick();
        tick();
        begin_acc(25'h1000000, 16'h0001, 1'b1);
        repeat (3) tick();
        int_src[0] = 1'b1;
        wait_en(20, n);
        finish_acc();
        rd_int(12'h000, d);
        checks++;
        if (d !== 16'h0001 || mpi_int !== 1'b1) begin
            failures++;
            $display("FAIL int_set_wins: stat=%h int=%b required 0001/1", d, mpi_int);
        end
        wr_int(12'h000, 16'h0001);
        rd_int(12'h000, d);
        checks++;
        if (d !== 16'h0000 || mpi_int !== 1'b0) begin
            failures++;
            $display("FAIL int_w1c: stat=%h int=%b required 0000/0", d, mpi_int);
        end
        int_src[3] = 1'b1;
        repeat (3) tick();
        checks++;
        if (mpi_int !== 1'b0) begin
            failures++;
            $display("FAIL int_masked: mpi_int=%b required 0", mpi_int);
        end
        rd_int(12'h000, d);
        checks++;
        if (d !== 16'h0008) begin
            failures++;
            $display("FAIL int_stat3: got %h required 0008", d);
        end
        wr_int(12'h001, 16'h0008);
        tick();
        checks++;
        if (mpi_int !== 1'b1) begin
            failures++;
            $display("FAIL int_unmask: mpi_int=%b required 1", mpi_int);
        end
    endtask

    task automatic test_reset_mid_access();
        int n;
        logic [15:0] d;
        begin_acc(25'h000F000, 16'h0000, 1'b0);
        wait_en(20, n);
        finish_acc();
        begin_acc(25'h0006000, 16'h0000, 1'b0);
        repeat (8) tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({mpi_en, mpi_int, cpu_ren, cpu_cs} !== 11'h0 || mpi_dout !== 16'h0000) begin
            failures++;
            $display("FAIL rst_abort: en=%b int=%b ren=%b cs=%h dout=%h required all 0",
                     mpi_en, mpi_int, cpu_ren, cpu_cs, mpi_dout);
        end
        tick();
        tick();
        rst = 1'b1;
        wen_cnt = 0;
        ren_cnt = 0;
        repeat (10) tick();
        checks++;
        if (wen_cnt != 0 || ren_cnt != 0 || mpi_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_cs_low: wen=%0d ren=%0d en=%b required 0/0/0",
                     wen_cnt, ren_cnt, mpi_en);
        end
        mpi_cs = 1'b1;
        repeat (4) tick();
        begin_acc(25'h0007001, 16'hA5A5, 1'b1);
        repeat (3) tick();
        checks++;
        if ({cpu_wen, cpu_cs, cpu_wdata} !== {1'b1, 8'h80, 16'hA5A5}) begin
            failures++;
            $display("FAIL rst_recover: wen/cs/wdata=%b/%h/%h required 1/80/A5A5",
                     cpu_wen, cpu_cs, cpu_wdata);
        end
        tick();
        finish_acc();
        rd_int(12'h003, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL rst_errcnt: got %h required 0000", d);
        end
    endtask

    initial begin
        rst       = 1'b0;
        mpi_cs    = 1'b1;
        mpi_wr    = 1'b0;
        mpi_a     = '0;
        mpi_din   = '0;
        cpu_rdata = '0;
        cpu_rvld  = '0;
        int_src   = '0;
        repeat (3) tick();
        test_reset();
        rst = 1'b1;
        repeat (4) tick();
        test_write();
        test_read_wait();
        test_read_strb_valid();
        test_early_release();
        test_timeout();
        test_unmapped();
        test_internal_regs();
        test_interrupts();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
